mult_unit_arbiter: RTL and testbench

//   Round-robin arbiter sharing one 24x24 mantissa multiply unit (MultiUnit)

---
 rtl/mult_unit_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mult_unit_arbiter.sv | 584 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_unit_arbiter.sv
// Round-robin arbiter that time-shares one 24x24 mantissa multiply unit between NREQ
// requesters, buffering their operands and routing each result back to its owner.
module mult_unit_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned IDW     = 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [NREQ-1:0]    req_trig,
    input  logic [NREQ*24-1:0] req_data1,
    input  logic [NREQ*24-1:0] req_data2,
    output logic [NREQ-1:0]    req_vld,
    output logic [22:0]        req_result,
    output logic [1:0]         req_other,
    output logic [23:0]        unit_data1,
    output logic [23:0]        unit_data2,
    output logic               unit_trig,
    input  logic [22:0]        unit_result,
    input  logic [1:0]         unit_other,
    input  logic               unit_vld,
    output logic               busy,
    output logic [IDW-1:0]     grant_id,
    output logic               err
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StIssue = 4'b0010,
        StWait  = 4'b0100,
        StResp  = 4'b1000
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] pend_q, pend_d, clr_mask, cap, vld_q, vld_d;
    logic [IDW-1:0]  last_q, last_d, grant_q, grant_d, pick, idx;
    logic            found;
    logic [23:0]     buf1_q [NREQ];
    logic [23:0]     buf2_q [NREQ];
    logic [23:0]     ud1_q, ud1_d, ud2_q, ud2_d;
    logic            utrig_q, utrig_d, busy_q, busy_d, err_q, err_d;
    logic [22:0]     res_q, res_d;
    logic [1:0]      oth_q, oth_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // First pending requester after the one served last, wrapping around.
    always_comb begin
        pick  = last_q;
        idx   = last_q;
        found = 1'b0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = IDW'((32'(last_q) + off) % NREQ);
            if (!found && pend_q[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        ud1_d    = ud1_q;
        ud2_d    = ud2_q;
        utrig_d  = 1'b0;
        vld_d    = '0;
        res_d    = res_q;
        oth_d    = oth_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        clr_mask = '0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = pick;
                    ud1_d   = buf1_q[pick];
                    ud2_d   = buf2_q[pick];
                    utrig_d = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (unit_vld) begin
                    res_d          = unit_result;
                    oth_d          = unit_other;
                    vld_d[grant_q] = 1'b1;
                    state_d        = StResp;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    res_d          = '0;
                    oth_d          = 2'b10;
                    vld_d[grant_q] = 1'b1;
                    err_d          = 1'b1;
                    state_d        = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                clr_mask[grant_q] = 1'b1;
                last_d            = grant_q;
                state_d           = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A completing job frees its slot before a same-edge trigger is judged.
        cap    = req_trig & ~(pend_q & ~clr_mask);
        pend_d = (pend_q & ~clr_mask) | cap;
        if ((req_trig & pend_q & ~clr_mask) != '0) begin
            err_d = 1'b1;
        end
        busy_d = (|pend_d) | (state_d != StIdle);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            pend_q  <= '0;
            last_q  <= IDW'(NREQ - 1);
            grant_q <= '0;
            ud1_q   <= '0;
            ud2_q   <= '0;
            utrig_q <= 1'b0;
            vld_q   <= '0;
            res_q   <= '0;
            oth_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                buf1_q[i] <= '0;
                buf2_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            ud1_q   <= ud1_d;
            ud2_q   <= ud2_d;
            utrig_q <= utrig_d;
            vld_q   <= vld_d;
            res_q   <= res_d;
            oth_q   <= oth_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            for (int i = 0; i < NREQ; i++) begin
                if (cap[i]) begin
                    buf1_q[i] <= req_data1[24*i +: 24];
                    buf2_q[i] <= req_data2[24*i +: 24];
                end
            end
        end
    end

    assign req_vld    = vld_q;
    assign req_result = res_q;
    assign req_other  = oth_q;
    assign unit_data1 = ud1_q;
    assign unit_data2 = ud2_q;
    assign unit_trig  = utrig_q;
    assign busy       = busy_q;
    assign grant_id   = grant_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mult_unit_arbiter.sv
// Bench for mult_unit_arbiter: emulates the shared multiply unit and checks grants,
// operands and results against a transaction-level round-robin model.
module tb_mult_unit_arbiter;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned IDW     = 1;

    logic               sys_clk   = 1'b0;
    logic               sys_rst_n = 1'b0;
    logic [NREQ-1:0]    req_trig  = '0;
    logic [NREQ*24-1:0] req_data1 = '0;
    logic [NREQ*24-1:0] req_data2 = '0;
    logic [NREQ-1:0]    req_vld;
    logic [22:0]        req_result;
    logic [1:0]         req_other;
    logic [23:0]        unit_data1, unit_data2;
    logic               unit_trig;
    logic [22:0]        unit_result;
    logic [1:0]         unit_other;
    logic               unit_vld;
    logic               busy;
    logic [IDW-1:0]     grant_id;
    logic               err;

    int          n_tests    = 0;
    int          n_fail     = 0;
    int          cyc        = 0;
    bit          unit_en    = 1'b1;
    bit          unit_fix   = 1'b0;
    int          unit_delay = 3;
    int          ucnt       = 0;
    logic [23:0] ua, ub;
    logic [23:0] op1 [NREQ];
    logic [23:0] op2 [NREQ];

    mult_unit_arbiter #(
        .NREQ   (NREQ),
        .TIMEOUT(TIMEOUT),
        .IDW    (IDW)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .req_trig   (req_trig),
        .req_data1  (req_data1),
        .req_data2  (req_data2),
        .req_vld    (req_vld),
        .req_result (req_result),
        .req_other  (req_other),
        .unit_data1 (unit_data1),
        .unit_data2 (unit_data2),
        .unit_trig  (unit_trig),
        .unit_result(unit_result),
        .unit_other (unit_other),
        .unit_vld   (unit_vld),
        .busy       (busy),
        .grant_id   (grant_id),
        .err        (err)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Behaviour of the shared multiply unit: {other, result}.
    function automatic logic [24:0] unit_fn(input logic [23:0] a, input logic [23:0] b);
        logic [47:0] p;
        p = 48'(a) * 48'(b);
        if (a == '0 || b == '0) return {2'b10, 23'd0};
        if (p[47]) return {2'b01, p[46:24]};
        return {2'b00, p[45:23]};
    endfunction

    // Unit emulator: answers unit_delay cycles after it sees unit_trig.
    initial begin
        unit_vld    = 1'b0;
        unit_result = '0;
        unit_other  = '0;
        forever begin
            @(negedge sys_clk);
            unit_vld = 1'b0;
            if (unit_trig && unit_en) begin
                ua   = unit_data1;
                ub   = unit_data2;
                ucnt = unit_delay;
            end else if (ucnt > 0) begin
                ucnt--;
                if (ucnt == 0) begin
                    if (unit_fix) {unit_other, unit_result} = {2'b01, 23'h400000};
                    else          {unit_other, unit_result} = unit_fn(ua, ub);
                    unit_vld = 1'b1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge sys_clk);
        req_trig = '0;
    endtask

    task automatic set_trig(input int j, input logic [23:0] a, input logic [23:0] b);
        req_trig[j]           = 1'b1;
        req_data1[24*j +: 24] = a;
        req_data2[24*j +: 24] = b;
        op1[j]                = a;
        op2[j]                = b;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        req_trig  = '0;
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int n_ut;
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        req_trig  = '1;
        repeat (2) @(negedge sys_clk);
        req_trig  = '0;
        sys_rst_n = 1'b1;
        n_tests++;
        if ({req_vld, req_result, req_other, unit_data1, unit_data2, unit_trig} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got vld=%0h res=%0h oth=%0h d1=%0h d2=%0h ut=%0b exp all 0",
                     req_vld, req_result, req_other, unit_data1, unit_data2, unit_trig);
        end
        n_tests++;
        if ({busy, grant_id, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy=%0b gid=%0h err=%0b exp 0", busy, grant_id, err);
        end
        n_ut = 0;
        repeat (5) begin
            step();
            if (unit_trig || busy) n_ut++;
        end
        n_tests++;
        if (n_ut != 0) begin
            n_fail++;
            $display("FAIL reset_trig_ignored: got %0d active cycles exp 0", n_ut);
        end
    endtask

    task automatic test_single();
        int k, t_edge, v_edge, n_ut, n_v;
        logic [23:0] d1, d2;
        logic [NREQ-1:0] vseen;
        logic [22:0] res;
        logic [1:0] oth;
        logic busy_mid;
        do_reset();
        unit_en = 1'b1; unit_fix = 1'b1; unit_delay = 10;
        step();
        set_trig(0, 24'h800000, 24'hC00000);
        k = cyc + 1;
        t_edge = -1; v_edge = -1; n_ut = 0; n_v = 0;
        vseen = '0; res = '0; oth = '0; d1 = '0; d2 = '0; busy_mid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (unit_trig) begin
                n_ut++;
                if (t_edge < 0) begin
                    t_edge = cyc; d1 = unit_data1; d2 = unit_data2; busy_mid = busy;
                end
            end
            if (req_vld != '0) begin
                n_v++; v_edge = cyc; vseen = req_vld; res = req_result; oth = req_other;
            end
        end
        unit_fix = 1'b0;
        n_tests++;
        if (n_ut != 1 || t_edge != k + 1) begin
            n_fail++;
            $display("FAIL t1_unit_trig: got count=%0d edge=%0d exp count=1 edge=%0d",
                     n_ut, t_edge, k + 1);
        end
        n_tests++;
        if (d1 !== 24'h800000 || d2 !== 24'hC00000) begin
            n_fail++;
            $display("FAIL t1_operands: got %0h %0h exp 800000 c00000", d1, d2);
        end
        n_tests++;
        if (busy_mid !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_busy_mid: got %0b exp 1", busy_mid);
        end
        // Grant edge k+1, unit answers 10 cycles later, sampled at k+12.
        n_tests++;
        if (n_v != 1 || vseen !== 2'b01 || v_edge != k + 12) begin
            n_fail++;
            $display("FAIL t1_req_vld: got count=%0d vld=%0b edge=%0d exp 1 01 %0d",
                     n_v, vseen, v_edge, k + 12);
        end
        n_tests++;
        if (res !== 23'h400000 || oth !== 2'b01) begin
            n_fail++;
            $display("FAIL t1_result: got %0h/%0b exp 400000/01", res, oth);
        end
        n_tests++;
        if (req_result !== 23'h400000 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_hold_idle: got res=%0h busy=%0b err=%0b exp 400000 0 0",
                     req_result, busy, err);
        end
    endtask

    task automatic test_collision();
        int g[$];
        int ge[$];
        logic [47:0] gops[$];
        logic [NREQ-1:0] vq[$];
        logic [24:0] rq[$];
        logic [23:0] a [NREQ];
        logic [23:0] b [NREQ];
        do_reset();
        unit_en = 1'b1; unit_delay = $urandom_range(1, 8);
        step();
        for (int j = 0; j < NREQ; j++) begin
            a[j] = 24'($urandom()); b[j] = 24'($urandom());
            set_trig(j, a[j], b[j]);
        end
        for (int i = 0; i < 100 && vq.size() < 2; i++) begin
            step();
            if (unit_trig) begin
                g.push_back(int'(grant_id)); ge.push_back(cyc);
                gops.push_back({unit_data1, unit_data2});
            end
            if (req_vld != '0) begin
                vq.push_back(req_vld); rq.push_back({req_other, req_result});
            end
        end
        n_tests++;
        if (g.size() != 2 || vq.size() != 2) begin
            n_fail++;
            $display("FAIL t2_counts: got grants=%0d vlds=%0d exp 2 2", g.size(), vq.size());
        end else begin
            n_tests++;
            if (g[0] != 0 || g[1] != 1) begin
                n_fail++;
                $display("FAIL t2_order: got %0d,%0d exp 0,1", g[0], g[1]);
            end
            n_tests++;
            if (gops[0] !== {a[0], b[0]} || gops[1] !== {a[1], b[1]}) begin
                n_fail++;
                $display("FAIL t2_operands: got %0h %0h exp %0h %0h",
                         gops[0], gops[1], {a[0], b[0]}, {a[1], b[1]});
            end
            n_tests++;
            if (vq[0] !== 2'b01 || vq[1] !== 2'b10) begin
                n_fail++;
                $display("FAIL t2_vld: got %0b,%0b exp 01,10", vq[0], vq[1]);
            end
            n_tests++;
            if (rq[0] !== unit_fn(a[0], b[0]) || rq[1] !== unit_fn(a[1], b[1])) begin
                n_fail++;
                $display("FAIL t2_results: got %0h %0h exp %0h %0h", rq[0], rq[1],
                         unit_fn(a[0], b[0]), unit_fn(a[1], b[1]));
            end
            n_tests++;
            if (ge[1] - ge[0] < 4) begin
                n_fail++;
                $display("FAIL t2_spacing: got %0d exp >=4", ge[1] - ge[0]);
            end
        end
    endtask

    task automatic test_fairness();
        int g[$];
        int nresp;
        int gid;
        do_reset();
        unit_en = 1'b1;
        step();
        for (int j = 0; j < NREQ; j++) set_trig(j, 24'($urandom()), 24'($urandom()));
        nresp = 0; gid = 0;
        for (int i = 0; i < 400 && nresp < 8; i++) begin
            step();
            unit_delay = $urandom_range(1, 5);
            if (unit_trig) begin
                gid = int'(grant_id);
                g.push_back(gid);
            end
            if (req_vld != '0) begin
                nresp++;
                n_tests++;
                if ({req_other, req_result} !== unit_fn(op1[gid], op2[gid])) begin
                    n_fail++;
                    $display("FAIL t3_result: got %0h exp %0h", {req_other, req_result},
                             unit_fn(op1[gid], op2[gid]));
                end
                set_trig(gid, 24'($urandom()), 24'($urandom()));
            end
        end
        repeat (60) step();
        n_tests++;
        if (g.size() < 8) begin
            n_fail++;
            $display("FAIL t3_count: got %0d grants exp >=8", g.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (g[i] != i % 2) begin
                    n_fail++;
                    $display("FAIL t3_alternate: grant %0d got %0d exp %0d", i, g[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_random();
        bit outstanding [NREQ];
        int trig_edge [NREQ];
        int last, granted, jobs, resp, expg, jj;
        logic [NREQ-1:0] expv;
        do_reset();
        unit_en = 1'b1;
        last = NREQ - 1; granted = -1; jobs = 0; resp = 0;
        for (int j = 0; j < NREQ; j++) begin
            outstanding[j] = 1'b0; trig_edge[j] = 0;
        end
        for (int i = 0; i < 3000; i++) begin
            step();
            if (unit_trig) begin
                expg = -1;
                for (int off = 1; off <= NREQ; off++) begin
                    jj = (last + off) % NREQ;
                    if (expg < 0 && outstanding[jj] && trig_edge[jj] < cyc) expg = jj;
                end
                n_tests++;
                if (expg < 0 || int'(grant_id) != expg) begin
                    n_fail++;
                    $display("FAIL rnd_grant: got %0d exp %0d at cyc %0d", grant_id, expg, cyc);
                end else begin
                    n_tests++;
                    if ({unit_data1, unit_data2} !== {op1[expg], op2[expg]}) begin
                        n_fail++;
                        $display("FAIL rnd_operands: got %0h %0h exp %0h %0h",
                                 unit_data1, unit_data2, op1[expg], op2[expg]);
                    end
                end
                granted = int'(grant_id);
                last    = granted;
            end
            if (req_vld != '0) begin
                n_tests++;
                if (granted < 0) begin
                    n_fail++;
                    $display("FAIL rnd_vld_nogrant: got vld=%0b exp no response", req_vld);
                end else begin
                    expv = NREQ'(1) << granted;
                    if (req_vld !== expv ||
                        {req_other, req_result} !== unit_fn(op1[granted], op2[granted])) begin
                        n_fail++;
                        $display("FAIL rnd_response: got vld=%0b r=%0h exp vld=%0b r=%0h",
                                 req_vld, {req_other, req_result}, expv,
                                 unit_fn(op1[granted], op2[granted]));
                    end
                    outstanding[granted] = 1'b0;
                    granted = -1;
                end
                resp++;
            end
            unit_delay = $urandom_range(1, 6);
            for (int j = 0; j < NREQ; j++) begin
                if (jobs < 40 && !outstanding[j] && $urandom_range(0, 3) == 0) begin
                    set_trig(j, 24'($urandom()), 24'($urandom()));
                    outstanding[j] = 1'b1;
                    trig_edge[j]   = cyc + 1;
                    jobs++;
                end
            end
            if (jobs >= 40 && resp >= jobs) break;
        end
        n_tests++;
        if (resp != 40 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_total: got resp=%0d err=%0b exp 40 0", resp, err);
        end
    endtask

    task automatic test_timeout();
        int t_edge, v_edge;
        logic err_before;
        logic [NREQ-1:0] vseen;
        logic [24:0] r;
        logic [23:0] c, d;
        do_reset();
        unit_en = 1'b0;
        step();
        set_trig(0, 24'h9ABCDE, 24'hF00001);
        t_edge = -1; v_edge = -1; err_before = 1'b1; vseen = '0; r = '0;
        for (int i = 0; i < TIMEOUT + 30 && v_edge < 0; i++) begin
            step();
            if (unit_trig && t_edge < 0) begin
                t_edge = cyc; err_before = err;
            end
            if (req_vld != '0) begin
                v_edge = cyc; vseen = req_vld; r = {req_other, req_result};
            end
        end
        n_tests++;
        if (err_before !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_err_early: got %0b exp 0", err_before);
        end
        // The abort lands about TIMEOUT cycles after the issue.
        n_tests++;
        if (t_edge < 0 || v_edge < t_edge + int'(TIMEOUT) - 1 || v_edge > t_edge + int'(TIMEOUT) + 1)
        begin
            n_fail++;
            $display("FAIL t4_latency: got %0d cycles exp %0d+-1", v_edge - t_edge, TIMEOUT);
        end
        n_tests++;
        if (vseen !== 2'b01 || r !== {2'b10, 23'd0} || err !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_abort: got vld=%0b r=%0h err=%0b exp 01 %0h 1", vseen, r, err,
                     {2'b10, 23'd0});
        end
        unit_en = 1'b1; unit_delay = 4;
        c = 24'($urandom()) | 24'h800000; d = 24'($urandom()) | 24'h800000;
        step(); step();
        set_trig(1, c, d);
        vseen = '0;
        for (int i = 0; i < 40 && vseen == '0; i++) begin
            step();
            if (req_vld != '0) begin
                vseen = req_vld; r = {req_other, req_result};
            end
        end
        n_tests++;
        if (vseen !== 2'b10 || r !== unit_fn(c, d) || err !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_next_job: got vld=%0b r=%0h err=%0b exp 10 %0h 1", vseen, r, err,
                     unit_fn(c, d));
        end
    endtask

    task automatic test_violation();
        logic [23:0] a1, a2, b1, b2;
        int g1_edge, n_v0, n_v1;
        bit viol2;
        logic [47:0] g1_ops;
        logic [24:0] r1;
        do_reset();
        unit_en = 1'b1; unit_delay = 12;
        a1 = 24'($urandom()); a2 = 24'($urandom());
        b1 = ~a1; b2 = ~a2;
        step();
        set_trig(0, 24'h812345, 24'hA00000);
        step();
        set_trig(1, a1, a2);
        repeat (4) step();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_err_before: got %0b exp 0", err);
        end
        req_trig[1] = 1'b1;
        req_data1[47:24] = b1;
        req_data2[47:24] = b2;
        step();
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_err_set: got %0b exp 1", err);
        end
        g1_edge = -1; n_v0 = 0; n_v1 = 0; viol2 = 1'b0; g1_ops = '0; r1 = '0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (unit_trig && grant_id == 1'b1 && g1_edge < 0) begin
                g1_edge = cyc; g1_ops = {unit_data1, unit_data2};
            end
            if (req_vld[0]) n_v0++;
            if (req_vld[1]) begin
                n_v1++; r1 = {req_other, req_result};
            end
            if (g1_edge >= 0 && cyc == g1_edge + 3 && !viol2) begin
                req_trig[1] = 1'b1;
                req_data1[47:24] = b1;
                req_data2[47:24] = b2;
                viol2 = 1'b1;
            end
        end
        n_tests++;
        if (g1_ops !== {a1, a2}) begin
            n_fail++;
            $display("FAIL t5_operands: got %0h exp %0h", g1_ops, {a1, a2});
        end
        n_tests++;
        if (n_v0 != 1 || n_v1 != 1 || r1 !== unit_fn(a1, a2)) begin
            n_fail++;
            $display("FAIL t5_single_vld: got v0=%0d v1=%0d r=%0h exp 1 1 %0h", n_v0, n_v1, r1,
                     unit_fn(a1, a2));
        end
        n_tests++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_final: got busy=%0b err=%0b exp 0 1", busy, err);
        end
    endtask

    task automatic test_reset_mid();
        int n_act, n_busy;
        logic [NREQ-1:0] vseen;
        logic [24:0] r;
        logic [23:0] c, d;
        bit seen_ut;
        do_reset();
        unit_en = 1'b1; unit_delay = 15;
        step();
        set_trig(0, 24'hC0FFEE, 24'hB00B00);
        seen_ut = 1'b0;
        for (int i = 0; i < 10 && !seen_ut; i++) begin
            step();
            if (unit_trig) seen_ut = 1'b1;
        end
        n_tests++;
        if (!seen_ut) begin
            n_fail++;
            $display("FAIL t6_issue: got no unit_trig exp one");
        end
        repeat (3) step();
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
        n_tests++;
        if ({req_vld, req_result, req_other, unit_data1, unit_data2, unit_trig, busy,
             grant_id, err} !== '0) begin
            n_fail++;
            $display("FAIL t6_outputs: got vld=%0b res=%0h busy=%0b gid=%0h d1=%0h exp all 0",
                     req_vld, req_result, busy, grant_id, unit_data1);
        end
        n_act = 0; n_busy = 0;
        repeat (30) begin
            step();
            if (req_vld != '0 || unit_trig) n_act++;
            if (busy) n_busy++;
        end
        n_tests++;
        if (n_act != 0 || n_busy != 0) begin
            n_fail++;
            $display("FAIL t6_quiet: got active=%0d busy=%0d exp 0 0", n_act, n_busy);
        end
        unit_delay = 3;
        c = 24'($urandom()); d = 24'($urandom());
        set_trig(0, c, d);
        vseen = '0; r = '0;
        for (int i = 0; i < 40 && vseen == '0; i++) begin
            step();
            if (req_vld != '0) begin
                vseen = req_vld; r = {req_other, req_result};
            end
        end
        n_tests++;
        if (vseen !== 2'b01 || r !== unit_fn(c, d)) begin
            n_fail++;
            $display("FAIL t6_retrigger: got vld=%0b r=%0h exp 01 %0h", vseen, r, unit_fn(c, d));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_collision();
        test_fairness();
        test_random();
        test_timeout();
        test_violation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
